branch_sequencer: RTL and testbench

//  Multi-cycle fetch/branch sequencer for the 32-bit CPU. It owns the PC and the sign/carry/zero flag register,

---
 rtl/isa_pkg.sv | 33 +++
 rtl/branch_cond_eval.sv | 36 +++
 rtl/branch_sequencer.sv | 163 ++++++++++++++++
 tb/tb_branch_sequencer.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch/branch sequencer: opcodes, FSM states, defaults.
package isa_pkg;

  localparam int unsigned OP_W = 6;

  // Branch opcodes (ir[31:26])
  localparam logic [OP_W-1:0] OP_BLTZ = 6'b000111;
  localparam logic [OP_W-1:0] OP_BZ   = 6'b001000;
  localparam logic [OP_W-1:0] OP_BNZ  = 6'b001001;
  localparam logic [OP_W-1:0] OP_B    = 6'b001010;
  localparam logic [OP_W-1:0] OP_BR   = 6'b001011;
  localparam logic [OP_W-1:0] OP_BL   = 6'b001100;
  localparam logic [OP_W-1:0] OP_BCY  = 6'b001101;
  localparam logic [OP_W-1:0] OP_BNCY = 6'b001110;

  localparam logic [OP_W-1:0] HALT_OP_DEFAULT = 6'b111111;

  // EXEC is the single issue cycle (exec_start high); EXEC_WAIT holds until exec_done.
  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXEC      = 3'd2,
    ST_EXEC_WAIT = 3'd3,
    ST_BRANCH    = 3'd4,
    ST_HALT      = 3'd5
  } state_e;

  // Opcode field of an instruction word.
  function automatic logic [OP_W-1:0] op_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch resolver: classifies an opcode and evaluates its condition on S/C/Z.
module branch_cond_eval
  import isa_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic            i_s,
  input  logic            i_c,
  input  logic            i_z,
  output logic            o_take,
  output logic            o_is_branch
);

  logic w_take;
  logic w_is_branch;

  // Decode opcode into branch class and taken condition.
  always_comb begin
    w_take      = 1'b0;
    w_is_branch = 1'b1;
    case (i_op)
      OP_BLTZ: w_take = i_s & ~i_z;
      OP_BZ:   w_take = ~i_s & i_z;
      OP_BNZ:  w_take = ~i_z;
      OP_B:    w_take = 1'b1;
      OP_BR:   w_take = 1'b1;
      OP_BL:   w_take = 1'b1;
      OP_BCY:  w_take = i_c;
      OP_BNCY: w_take = ~i_c;
      default: w_is_branch = 1'b0;
    endcase
  end

  assign o_take      = w_take;
  assign o_is_branch = w_is_branch;

endmodule

// File: rtl/branch_sequencer.sv
// Multi-cycle fetch/branch sequencer: owns PC, IR and the S/C/Z flags, fetches over req/valid,
// hands non-branch instructions to the datapath and resolves branches itself.
module branch_sequencer
  import isa_pkg::*;
#(
  parameter int unsigned          ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]    RESET_PC = {ADDR_W{1'b0}},
  parameter logic [OP_W-1:0]      HALT_OP  = HALT_OP_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  output logic              instr_req,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic              instr_valid,
  input  logic [31:0]       instr_data,
  output logic [31:0]       ir,
  input  logic [31:0]       rs_value,
  output logic              exec_start,
  input  logic              exec_done,
  input  logic              flags_we,
  input  logic              alu_sign,
  input  logic              alu_carry,
  input  logic              alu_zero,
  output logic              link_we,
  output logic [ADDR_W-1:0] link_data,
  output logic              halted
);

  state_e            r_state;
  state_e            w_next_state;
  logic              r_run;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_ir;
  logic              r_flag_s;
  logic              r_flag_c;
  logic              r_flag_z;

  logic [OP_W-1:0]   w_op;
  logic              w_take;
  logic              w_is_branch;
  logic [ADDR_W-1:0] w_pc_plus4;
  logic [ADDR_W-1:0] w_off26;
  logic [ADDR_W-1:0] w_off16;
  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_branch_pc;
  logic              w_fetch_fire;
  logic              w_exec_fire;

  assign w_op        = op_of(r_ir);
  assign w_pc_plus4  = r_pc + ADDR_W'(3'd4);
  assign w_off26     = {{(ADDR_W-28){r_ir[25]}}, r_ir[25:0], 2'b00};
  assign w_off16     = {{(ADDR_W-18){r_ir[15]}}, r_ir[15:0], 2'b00};
  assign w_branch_pc = w_take ? w_target : w_pc_plus4;

  // r_run keeps the fetch request low for the first cycle after reset release.
  assign w_fetch_fire = r_run & instr_valid & (r_state == ST_FETCH);
  assign w_exec_fire  = exec_done & ((r_state == ST_EXEC) | (r_state == ST_EXEC_WAIT));

  branch_cond_eval u_cond (
    .i_op        (w_op),
    .i_s         (r_flag_s),
    .i_c         (r_flag_c),
    .i_z         (r_flag_z),
    .o_take      (w_take),
    .o_is_branch (w_is_branch)
  );

  // Branch target select: long offset for b/bl, register for br, short offset otherwise.
  always_comb begin
    w_target = w_pc_plus4 + w_off16;
    case (w_op)
      OP_B, OP_BL: w_target = w_pc_plus4 + w_off26;
      OP_BR:       w_target = rs_value[ADDR_W-1:0];
      default:     w_target = w_pc_plus4 + w_off16;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Fetch enable: set one cycle after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run <= 1'b0;
    end else begin
      r_run <= 1'b1;
    end
  end

  // FSM next-state logic; HALT_OP is checked before the branch class.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_FETCH: begin
        if (w_fetch_fire) w_next_state = ST_DECODE;
        else              w_next_state = ST_FETCH;
      end
      ST_DECODE: begin
        if (w_op == HALT_OP)  w_next_state = ST_HALT;
        else if (w_is_branch) w_next_state = ST_BRANCH;
        else                  w_next_state = ST_EXEC;
      end
      ST_EXEC, ST_EXEC_WAIT: begin
        if (exec_done) w_next_state = ST_FETCH;
        else           w_next_state = ST_EXEC_WAIT;
      end
      ST_BRANCH: w_next_state = ST_FETCH;
      ST_HALT:   w_next_state = ST_HALT;
      default:   w_next_state = ST_FETCH;
    endcase
  end

  // FSM outputs decoded from the registered state.
  always_comb begin
    instr_req  = 1'b0;
    exec_start = 1'b0;
    link_we    = 1'b0;
    halted     = 1'b0;
    case (r_state)
      ST_FETCH:  instr_req  = r_run;
      ST_EXEC:   exec_start = 1'b1;
      ST_BRANCH: link_we    = (w_op == OP_BL);
      ST_HALT:   halted     = 1'b1;
      default:   instr_req  = 1'b0;
    endcase
  end

  // PC, IR and flag registers; flags change only on a flag-writing completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc     <= RESET_PC;
      r_ir     <= 32'h0000_0000;
      r_flag_s <= 1'b0;
      r_flag_c <= 1'b0;
      r_flag_z <= 1'b0;
    end else begin
      if (w_fetch_fire) begin
        r_ir <= instr_data;
      end
      if (w_exec_fire) begin
        r_pc <= w_pc_plus4;
        if (flags_we) begin
          r_flag_s <= alu_sign;
          r_flag_c <= alu_carry;
          r_flag_z <= alu_zero;
        end
      end else if (r_state == ST_BRANCH) begin
        r_pc <= w_branch_pc;
      end
    end
  end

  assign instr_addr = r_pc;
  assign ir         = r_ir;
  assign link_data  = w_pc_plus4;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed vector table, random program with a
// reference model, reset-during-exec and halt sequences.
module tb_branch_sequencer;
  import isa_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [5:0]  ALU_OP = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] ir;
  logic [31:0] rs_value;
  logic        exec_start;
  logic        exec_done;
  logic        flags_we;
  logic        alu_sign, alu_carry, alu_zero;
  logic        link_we;
  logic [31:0] link_data;
  logic        halted;

  int checks = 0;
  int errors = 0;

  // Reference model state: architectural PC and flags
  logic [31:0] m_pc;
  logic        m_s, m_c, m_z;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] rs;
    logic        fwe;
    logic        s, c, z;
    logic [31:0] exp_next;
    logic        exp_link;
    logic [31:0] exp_link_data;
  } vec_t;

  vec_t tbl[16];

  branch_sequencer #(.ADDR_W(32), .RESET_PC(RST_PC), .HALT_OP(HALT_OP_DEFAULT)) dut (
    .clk(clk), .rst(rst),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .ir(ir), .rs_value(rs_value),
    .exec_start(exec_start), .exec_done(exec_done), .flags_we(flags_we),
    .alu_sign(alu_sign), .alu_carry(alu_carry), .alu_zero(alu_zero),
    .link_we(link_we), .link_data(link_data), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] enc16(input logic [5:0] op, input int imm);
    return {op, 10'd0, 16'(imm)};
  endfunction

  function automatic logic [31:0] enc26(input logic [5:0] op, input int imm);
    return {op, 26'(imm)};
  endfunction

  function automatic vec_t mk(input logic [31:0] instr, input logic [31:0] rs, input logic fwe,
                              input logic s, input logic c, input logic z, input logic [31:0] nxt,
                              input logic lk, input logic [31:0] ld);
    vec_t v;
    v.instr = instr; v.rs = rs; v.fwe = fwe; v.s = s; v.c = c; v.z = z;
    v.exp_next = nxt; v.exp_link = lk; v.exp_link_data = ld;
    return v;
  endfunction

  // Branch opcodes occupy the contiguous range 7..14
  function automatic bit ref_is_branch(input logic [5:0] op);
    return (op >= 6'd7) && (op <= 6'd14);
  endfunction

  function automatic bit ref_take(input logic [5:0] op, input logic s, input logic c, input logic z);
    case (op)
      6'd7:    return s && !z;
      6'd8:    return !s && z;
      6'd9:    return !z;
      6'd13:   return c;
      6'd14:   return !c;
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] ref_target(input logic [31:0] pc, input logic [31:0] instr,
                                             input logic [31:0] rs);
    logic [5:0]         op;
    logic signed [25:0] i26;
    logic signed [15:0] i16;
    int                 off;
    op  = instr[31:26];
    i26 = instr[25:0];
    i16 = instr[15:0];
    if (op == 6'd11) return rs;
    if (op == 6'd10 || op == 6'd12) off = int'(i26) * 4;
    else                            off = int'(i16) * 4;
    return pc + 32'd4 + 32'(off);
  endfunction

  task automatic model_step(input logic [31:0] instr, input logic [31:0] rs, input logic fwe,
                            input logic s, input logic c, input logic z);
    logic [5:0] op;
    op = instr[31:26];
    if (op == HALT_OP_DEFAULT) begin
      m_pc = m_pc;
    end else if (ref_is_branch(op)) begin
      m_pc = ref_take(op, m_s, m_c, m_z) ? ref_target(m_pc, instr, rs) : m_pc + 32'd4;
    end else begin
      m_pc = m_pc + 32'd4;
      if (fwe) begin m_s = s; m_c = c; m_z = z; end
    end
  endtask

  task automatic wait_fetch(input logic [31:0] exp, input string name);
    int n;
    n = 0;
    while (instr_req !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (instr_req !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: instr_req got %b expected 1", name, instr_req);
    end else begin
      chk(name, instr_addr, exp);
    end
  endtask

  // Runs one instruction starting from a fetch request; ends in the next FETCH (or HALT).
  task automatic issue(input logic [31:0] instr, input logic [31:0] rs, input logic fwe,
                       input logic s, input logic c, input logic z, input int fdly, input int edly,
                       input logic exp_link, input logic [31:0] exp_link_data);
    logic [5:0] op;
    int         starts;
    bit         moved;
    op = instr[31:26];
    moved = 1'b0;
    for (int i = 0; i < fdly; i++) begin
      exec_done = 1'($urandom_range(0, 1));
      flags_we  = 1'b1;
      alu_sign  = 1'($urandom_range(0, 1));
      alu_carry = 1'($urandom_range(0, 1));
      alu_zero  = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (instr_req !== 1'b1 || instr_addr !== m_pc) moved = 1'b1;
    end
    exec_done = 1'b0;
    flags_we  = 1'b0;
    if (fdly > 0) chk("fetch_hold", 32'(moved), 32'd0);
    instr_valid = 1'b1;
    instr_data  = instr;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data  = $urandom;
    chk("ir_latch", ir, instr);
    chk("decode_req", 32'(instr_req), 32'd0);
    rs_value = rs;
    @(posedge clk); #1;
    if (op == HALT_OP_DEFAULT) begin
      chk("halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(instr_req), 32'd0);
      return;
    end
    if (ref_is_branch(op)) begin
      chk("link_we", 32'(link_we), 32'(exp_link));
      if (exp_link) chk("link_data", link_data, exp_link_data);
      chk("branch_no_start", 32'(exec_start), 32'd0);
      model_step(instr, rs, fwe, s, c, z);
      @(posedge clk); #1;
      chk("link_pulse_end", 32'(link_we), 32'd0);
    end else begin
      starts = (exec_start === 1'b1) ? 1 : 0;
      for (int i = 0; i < edly; i++) begin
        instr_valid = 1'($urandom_range(0, 1));
        instr_data  = $urandom;
        @(posedge clk); #1;
        if (exec_start === 1'b1) starts++;
      end
      instr_valid = 1'b0;
      exec_done   = 1'b1;
      flags_we    = fwe;
      alu_sign    = s;
      alu_carry   = c;
      alu_zero    = z;
      @(posedge clk); #1;
      exec_done = 1'b0;
      flags_we  = 1'b0;
      chk("exec_start_pulse", 32'(starts), 32'd1);
      model_step(instr, rs, fwe, s, c, z);
    end
  endtask

  initial begin
    logic [5:0]  op;
    logic [31:0] instr;
    logic [31:0] rs;
    logic        fwe, s, c, z;

    rst = 1'b0;
    instr_valid = 1'b0; instr_data = 32'h0; rs_value = 32'h0;
    exec_done = 1'b0; flags_we = 1'b0;
    alu_sign = 1'b0; alu_carry = 1'b0; alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(instr_req), 32'd0);
    chk("rst_addr", instr_addr, RST_PC);
    chk("rst_ir", ir, 32'h0);
    chk("rst_start", 32'(exec_start), 32'd0);
    chk("rst_link", 32'(link_we), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    m_pc = RST_PC; m_s = 1'b0; m_c = 1'b0; m_z = 1'b0;
    wait_fetch(RST_PC, "reset_fetch");

    tbl[0]  = mk({ALU_OP, 26'd0},      32'h0,         1'b1, 1'b0, 1'b1, 1'b0, 32'h0000_0104, 1'b0, 32'h0);
    tbl[1]  = mk(enc16(OP_BCY, 4),     32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0118, 1'b0, 32'h0);
    tbl[2]  = mk(enc16(OP_BNCY, 4),    32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_011C, 1'b0, 32'h0);
    tbl[3]  = mk(enc26(OP_B, 32'h38),  32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1'b0, 32'h0);
    tbl[4]  = mk(enc26(OP_BL, -2),     32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_01FC, 1'b1, 32'h0000_0204);
    tbl[5]  = mk({OP_BR, 26'd0},       32'h0000_3000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3000, 1'b0, 32'h0);
    tbl[6]  = mk({ALU_OP, 26'd1},      32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_3004, 1'b0, 32'h0);
    tbl[7]  = mk(enc16(OP_BLTZ, 2),    32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3010, 1'b0, 32'h0);
    tbl[8]  = mk(enc16(OP_BZ, 2),      32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3014, 1'b0, 32'h0);
    tbl[9]  = mk({ALU_OP, 26'd2},      32'h0,         1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3018, 1'b0, 32'h0);
    tbl[10] = mk(enc16(OP_BLTZ, -1),   32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3018, 1'b0, 32'h0);
    tbl[11] = mk({ALU_OP, 26'd3},      32'h0,         1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_301C, 1'b0, 32'h0);
    tbl[12] = mk(enc16(OP_BZ, 1),      32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3024, 1'b0, 32'h0);
    tbl[13] = mk(enc16(OP_BNZ, 1),     32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_3028, 1'b0, 32'h0);
    tbl[14] = mk({OP_BR, 26'd0},       32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 32'h0);
    tbl[15] = mk(enc26(OP_B, 1),       32'h0,         1'b0, 1'b0, 1'b0, 1'b0, 32'h0000_0004, 1'b0, 32'h0);

    for (int i = 0; i < 16; i++) begin
      issue(tbl[i].instr, tbl[i].rs, tbl[i].fwe, tbl[i].s, tbl[i].c, tbl[i].z,
            (i == 0) ? 3 : (i % 3), i % 4, tbl[i].exp_link, tbl[i].exp_link_data);
      wait_fetch(tbl[i].exp_next, $sformatf("tbl%0d_next", i));
    end

    // Random program against the reference model
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        op = 6'(7 + $urandom_range(0, 7));
      end else begin
        op = 6'($urandom_range(0, 62));
        if (ref_is_branch(op)) op = op + 6'd8;
      end
      instr = {op, 26'($urandom)};
      rs    = $urandom;
      fwe   = 1'($urandom_range(0, 1));
      s     = 1'($urandom_range(0, 1));
      c     = 1'($urandom_range(0, 1));
      z     = 1'($urandom_range(0, 1));
      issue(instr, rs, fwe, s, c, z, $urandom_range(0, 3), $urandom_range(0, 3),
            (op == OP_BL), m_pc + 32'd4);
      wait_fetch(m_pc, "rand_next");
    end

    // Reset while an instruction is executing; late exec_done must be discarded
    issue({ALU_OP, 26'd0}, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1'b0, 32'h0);
    wait_fetch(m_pc, "pre_rst_next");
    instr_valid = 1'b1;
    instr_data  = {ALU_OP, 26'd5};
    @(posedge clk); #1;
    instr_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec_start", 32'(exec_start), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rst_req_drop", 32'(instr_req), 32'd0);
    chk("rst_start_drop", 32'(exec_start), 32'd0);
    chk("rst_pc_async", instr_addr, RST_PC);
    chk("rst_ir_async", ir, 32'h0);
    exec_done = 1'b1; flags_we = 1'b1; alu_carry = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    m_pc = RST_PC; m_s = 1'b0; m_c = 1'b0; m_z = 1'b0;
    @(posedge clk); #1;
    exec_done = 1'b0; flags_we = 1'b0; alu_carry = 1'b0;
    wait_fetch(RST_PC, "rst_refetch");
    issue(enc16(OP_BZ, 4), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0);
    wait_fetch(32'h0000_0104, "post_rst_bz");
    issue(enc16(OP_BCY, 4), 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1'b0, 32'h0);
    wait_fetch(32'h0000_0108, "post_rst_bcy");

    // Halt is terminal: no further requests even with stray responses
    issue({HALT_OP_DEFAULT, 26'd0}, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 1'b0, 32'h0);
    repeat (5) begin
      instr_valid = 1'b1;
      exec_done   = 1'b1;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    exec_done   = 1'b0;
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_no_req", 32'(instr_req), 32'd0);
    chk("halt_pc_frozen", instr_addr, 32'h0000_0108);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
